apb_responder: RTL and testbench
================================

# apb_responder

APB completer: the target end of the APB bus driven by the CPU data path. It decodes a 16-bit word address, serves reads and writes from an internal 16-bit word memory, and inserts a programmable number of wait states. Out-of-range accesses complete with an error response. It is the generic memory/peripheral endpoint the CPU's ALU load/store path talks to over APB.

## Interface
Parameters:
- DEPTH, 64: number of 16-bit words; power of two, 2..4096.
- BASE_ADDR, 16'h0000: word address of entry 0; must be DEPTH-aligned.
- WAIT_STATES, 1: access-phase cycles with pready low before completion, 0..15.

Ports:
- clk  in  1  single clock; everything updates on the rising edge.
- reset  in  1  asynchronous, active-high; all state cleared immediately while high.
- psel  in  1  select from initiator.
- penable  in  1  access-phase flag.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  16  word address.
- pwdata  in  16  write data.
- prdata  out  16  read data, valid while pready = 1.
- pready  out  1  transfer completes on the edge where psel & penable & pready are all 1.
- pslverr  out  1  error flag; meaningful only while pready = 1.
- wr_strobe  out  1  one-cycle pulse on the cycle after a memory write commits.
- busy  out  1  high while in ACCESS.

## Operation
- States: IDLE, ACCESS.
- IDLE: on an edge with psel = 1 and penable = 0 (setup phase), latch addr_q = paddr, write_q = pwrite, wdata_q = pwdata. Set hit_q = (paddr − BASE_ADDR) < DEPTH, using 16-bit unsigned subtraction, so addresses below BASE wrap and miss. Load cnt = WAIT_STATES, load prdata = hit ? mem[paddr − BASE_ADDR] : 16'h0000, and go to ACCESS.
- IDLE with penable = 1 (no preceding setup) is ignored; the block stays in IDLE.
- ACCESS:
  - pready = (cnt == 0) and pslverr = pready & ~hit_q, both combinational from registered state.
  - Each edge with cnt != 0 and psel = 1: cnt decrements.
  - Edge with psel & penable & pready: if write_q & hit_q, mem[index] <= wdata_q and wr_strobe pulses next cycle. Then go to IDLE.
  - psel = 0 in ACCESS (abort): return to IDLE with no memory write and no wr_strobe.
- A read of an address written in the immediately preceding transfer returns the new data, because the write commits before the next setup edge.
- Writes to a miss are dropped and memory is unchanged. Reads of a miss return 16'h0000 with pslverr = 1.
- busy = (state == ACCESS).

## Timing
- Reset values: state IDLE, cnt 0, prdata 16'h0000, wr_strobe 0. pready and pslverr are 0 because state is IDLE. Memory contents are cleared to 0.
- Reset mid-ACCESS drops the transfer; no write commits.
- Setup at edge E0. pready rises in the cycle after E0 + WAIT_STATES edges. Completion edge is E0 + WAIT_STATES + 1.
  - WAIT_STATES = 0 gives a 2-cycle transfer (setup + 1 access).
  - WAIT_STATES = 3 gives a 5-cycle transfer.
- Back-to-back: a setup presented in the cycle right after the completion edge is accepted, so there are no idle bubbles.
- prdata is stable from the cycle after E0 until the next setup edge.
- wr_strobe is high exactly one cycle, the cycle after the completion edge.

## Test plan
- Reset, WAIT_STATES = 1, DEPTH = 64: write 16'hBEEF to 16'h0005, then read 16'h0005. Expect pready high in the 3rd cycle of each transfer, prdata = 16'hBEEF, pslverr = 0, one wr_strobe pulse.
- WAIT_STATES = 0, BASE_ADDR = 16'h0040: read 16'h003F and 16'h0080. Expect 2-cycle transfers with pslverr = 1 and prdata = 0. Write 16'h1234 to 16'h0080; memory is unchanged and no wr_strobe.
- WAIT_STATES = 3: back-to-back write to 16'h0000 then read of 16'h0000. Expect two 5-cycle transfers with no gap and prdata = written data.
- Abort: drop psel in the 2nd access cycle with WAIT_STATES = 3. Expect return to IDLE, busy = 0, no wr_strobe, and a later read returns the old data.
- Assert reset asynchronously mid-ACCESS of a write. Expect pready, busy and prdata to go to 0 immediately, and the target word reads 0 afterward.
- Drive penable = 1 without a setup phase. Expect pready to stay 0 and the state to stay IDLE.

Source files
------------

// File: rtl/apb_responder.sv
// apb_responder: APB completer backed by a DEPTH x 16-bit word memory.
// The completer decodes a word address against BASE_ADDR and inserts WAIT_STATES
// wait cycles. A miss completes with pslverr set and returns 16'h0000.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   psel, penable, pwrite  APB control from the initiator
//   paddr, pwdata          16-bit word address and write data
//   prdata                 read data (registered), valid while pready = 1
//   pready, pslverr        completion and error, decoded from registered state
//   wr_strobe              registered one-cycle pulse after a memory write commits
//   busy                   high while a transfer is in its access phase
module apb_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [15:0] paddr,
  input  logic [15:0] pwdata,
  output logic [15:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        wr_strobe,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          write_q, write_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          hit_q, hit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   prdata_q, prdata_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic          mem_we_c;
  logic [15:0]   mem_q [DEPTH];

  logic [15:0]   offs_c;
  logic [AW-1:0] offs_idx_c;
  logic          offs_hit_c;
  logic          done_c;

  // Offset from the window base; addresses below BASE_ADDR wrap high and miss.
  assign offs_c     = paddr - BASE_ADDR;
  assign offs_idx_c = offs_c[AW-1:0];
  assign offs_hit_c = (offs_c >> AW) == 16'h0000;

  assign busy      = (state_q == ST_ACCESS);
  assign pready    = busy && (cnt_q == '0);
  assign pslverr   = pready & ~hit_q;
  assign prdata    = prdata_q;
  assign wr_strobe = wr_strobe_q;

  assign done_c = psel & penable & pready;

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    hit_d       = hit_q;
    cnt_d       = cnt_q;
    prdata_d    = prdata_q;
    wr_strobe_d = 1'b0;
    mem_we_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only a genuine setup phase starts a transfer; a stray penable is ignored.
        if (psel && !penable) begin
          state_d  = ST_ACCESS;
          idx_d    = offs_idx_c;
          write_d  = pwrite;
          wdata_d  = pwdata;
          hit_d    = offs_hit_c;
          cnt_d    = CW'(WAIT_STATES);
          prdata_d = offs_hit_c ? mem_q[offs_idx_c] : 16'h0000;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (done_c) begin
          state_d = ST_IDLE;
          if (write_q && hit_q) begin
            mem_we_c    = 1'b1;
            wr_strobe_d = 1'b1;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  // State, datapath and memory registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      write_q     <= 1'b0;
      wdata_q     <= 16'h0000;
      hit_q       <= 1'b0;
      cnt_q       <= '0;
      prdata_q    <= 16'h0000;
      wr_strobe_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[AW'(i)] <= 16'h0000;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      hit_q       <= hit_d;
      cnt_q       <= cnt_d;
      prdata_q    <= prdata_d;
      wr_strobe_q <= wr_strobe_d;
      if (mem_we_c) begin
        mem_q[idx_q] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_apb_responder.sv
// Bench for apb_responder: three instances with different base/wait settings,
// driven one transfer at a time against a transfer-level model of the memory.
module tb_apb_responder;

  localparam int unsigned NI  = 3;
  localparam int unsigned DEP = 64;

  function automatic logic [15:0] base_of(input int k);
    return (k == 1) ? 16'h0040 : 16'h0000;
  endfunction

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        psel_a    [NI];
  logic        penable_a [NI];
  logic        pwrite_a  [NI];
  logic [15:0] paddr_a   [NI];
  logic [15:0] pwdata_a  [NI];
  logic [15:0] prdata_a  [NI];
  logic        pready_a  [NI];
  logic        pslverr_a [NI];
  logic        wrs_a     [NI];
  logic        busy_a    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    apb_responder #(
      .DEPTH      (DEP),
      .BASE_ADDR  ((g == 1) ? 16'h0040 : 16'h0000),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .psel     (psel_a[g]),
      .penable  (penable_a[g]),
      .pwrite   (pwrite_a[g]),
      .paddr    (paddr_a[g]),
      .pwdata   (pwdata_a[g]),
      .prdata   (prdata_a[g]),
      .pready   (pready_a[g]),
      .pslverr  (pslverr_a[g]),
      .wr_strobe(wrs_a[g]),
      .busy     (busy_a[g])
    );
  end

  // Model state: memory image plus what each output must show this cycle.
  logic [15:0] mem_m [NI][DEP];
  logic [15:0] exp_prdata  [NI];
  logic        exp_busy    [NI];
  logic        exp_pready  [NI];
  logic        exp_pslverr [NI];
  logic        exp_wrs     [NI];
  logic        pend_wrs    [NI];
  logic        chk_en;

  int checks   = 0;
  int failures = 0;
  int wrs_cnt   [NI] = '{default: 0};
  int acc       [NI] = '{default: 0};
  int last_wait [NI] = '{default: 99};

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", nm, k, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, plus wait-state and strobe monitors.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (chk_en) begin
        chk("busy",      k, 16'(busy_a[k]),   16'(exp_busy[k]));
        chk("pready",    k, 16'(pready_a[k]), 16'(exp_pready[k]));
        if (exp_pready[k]) chk("pslverr", k, 16'(pslverr_a[k]), 16'(exp_pslverr[k]));
        chk("prdata",    k, prdata_a[k],      exp_prdata[k]);
        chk("wr_strobe", k, 16'(wrs_a[k]),    16'(exp_wrs[k]));
      end
      if (wrs_a[k]) wrs_cnt[k]++;
      if (busy_a[k]) begin
        if (pready_a[k]) last_wait[k] = acc[k];
        acc[k]++;
      end else begin
        acc[k] = 0;
      end
    end
  end

  // Advance one cycle; every instance defaults to idle bus and idle expectations.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      exp_wrs[k]     = pend_wrs[k];
      pend_wrs[k]    = 1'b0;
      psel_a[k]      = 1'b0;
      penable_a[k]   = 1'b0;
      exp_busy[k]    = 1'b0;
      exp_pready[k]  = 1'b0;
      exp_pslverr[k] = 1'b0;
    end
  endtask

  // One transfer; cut_kind 1 drops psel, 2 asserts reset, at access cycle cut_j.
  task automatic xfer(input int k, input logic w, input logic [15:0] a, input logic [15:0] d,
                      input int cut_j, input int cut_kind);
    logic [15:0] idx;
    logic        hit;
    logic [15:0] npr;
    int          ws;
    ws  = ws_of(k);
    idx = a - base_of(k);
    hit = (idx < 16'(DEP));
    step();
    psel_a[k]    = 1'b1;
    penable_a[k] = 1'b0;
    pwrite_a[k]  = w;
    paddr_a[k]   = a;
    pwdata_a[k]  = d;
    npr = hit ? mem_m[k][idx[5:0]] : 16'h0000;
    for (int j = 0; j <= ws; j++) begin
      step();
      exp_prdata[k]  = npr;
      exp_busy[k]    = 1'b1;
      exp_pready[k]  = (j == ws);
      exp_pslverr[k] = (j == ws) && !hit;
      psel_a[k]      = 1'b1;
      penable_a[k]   = 1'b1;
      if (j == cut_j && cut_kind == 1) begin
        psel_a[k]    = 1'b0;
        penable_a[k] = 1'b0;
        return;
      end
      if (j == cut_j && cut_kind == 2) begin
        #1;
        chk_en = 1'b0;
        reset  = 1'b1;
        return;
      end
      if (j == ws && w && hit) begin
        mem_m[k][idx[5:0]] = d;
        pend_wrs[k] = 1'b1;
      end
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < DEP; i++) mem_m[k][i] = 16'h0000;
      exp_prdata[k]  = 16'h0000;
      exp_busy[k]    = 1'b0;
      exp_pready[k]  = 1'b0;
      exp_pslverr[k] = 1'b0;
      exp_wrs[k]     = 1'b0;
      pend_wrs[k]    = 1'b0;
      psel_a[k]      = 1'b0;
      penable_a[k]   = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, cut_j, cut_kind;
    logic w;
    logic [15:0] a;

    chk_en = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < NI; i++) begin
      pwrite_a[i] = 1'b0;
      paddr_a[i]  = 16'h0000;
      pwdata_a[i] = 16'h0000;
    end
    model_clear();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_prdata",  i, prdata_a[i],        16'h0000);
      chk("rst_pready",  i, 16'(pready_a[i]),   16'h0000);
      chk("rst_pslverr", i, 16'(pslverr_a[i]),  16'h0000);
      chk("rst_busy",    i, 16'(busy_a[i]),     16'h0000);
      chk("rst_wrs",     i, 16'(wrs_a[i]),      16'h0000);
    end
    reset  = 1'b0;
    chk_en = 1'b1;

    // One wait state: write then read back.
    xfer(0, 1'b1, 16'h0005, 16'hBEEF, -1, 0);
    xfer(0, 1'b0, 16'h0005, 16'h0000, -1, 0);
    step();
    chk("t1_prdata", 0, prdata_a[0], 16'hBEEF);
    chk("t1_wrs_cnt", 0, 16'(wrs_cnt[0]), 16'd1);
    chk("t1_wait", 0, 16'(last_wait[0]), 16'd1);

    // Zero wait states, window at 0x0040: hits, misses below and above, dropped write.
    xfer(1, 1'b1, 16'h0040, 16'hA5A5, -1, 0);
    xfer(1, 1'b0, 16'h0040, 16'h0000, -1, 0);
    xfer(1, 1'b0, 16'h003F, 16'h0000, -1, 0);
    step();
    chk("t2_miss_lo", 1, prdata_a[1], 16'h0000);
    xfer(1, 1'b0, 16'h0080, 16'h0000, -1, 0);
    xfer(1, 1'b1, 16'h0080, 16'h1234, -1, 0);
    step();
    chk("t2_miss_wrs", 1, 16'(wrs_cnt[1]), 16'd1);
    xfer(1, 1'b0, 16'h0040, 16'h0000, -1, 0);
    step();
    chk("t2_unchanged", 1, prdata_a[1], 16'hA5A5);
    chk("t2_wait", 1, 16'(last_wait[1]), 16'd0);

    // Three wait states, back-to-back write and read.
    xfer(2, 1'b1, 16'h0000, 16'h5A3C, -1, 0);
    xfer(2, 1'b0, 16'h0000, 16'h0000, -1, 0);
    step();
    chk("t3_prdata", 2, prdata_a[2], 16'h5A3C);
    chk("t3_wait", 2, 16'(last_wait[2]), 16'd3);

    // Abort in the second access cycle.
    xfer(2, 1'b1, 16'h0000, 16'hDEAD, 1, 1);
    step();
    chk("t4_busy", 2, 16'(busy_a[2]), 16'h0000);
    xfer(2, 1'b0, 16'h0000, 16'h0000, -1, 0);
    step();
    chk("t4_old", 2, prdata_a[2], 16'h5A3C);
    chk("t4_wrs_cnt", 2, 16'(wrs_cnt[2]), 16'd1);

    // Asynchronous reset in the completing cycle of a write.
    xfer(2, 1'b1, 16'h0000, 16'h7777, 3, 2);
    #1;
    chk("t5_pready", 2, 16'(pready_a[2]), 16'h0000);
    chk("t5_busy",   2, 16'(busy_a[2]),   16'h0000);
    chk("t5_prdata", 2, prdata_a[2],      16'h0000);
    chk("t5_prdata0", 0, prdata_a[0],     16'h0000);
    model_clear();
    @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    xfer(2, 1'b0, 16'h0000, 16'h0000, -1, 0);
    xfer(0, 1'b0, 16'h0005, 16'h0000, -1, 0);
    step();
    chk("t5_after", 2, prdata_a[2], 16'h0000);

    // penable without a setup phase is ignored.
    for (int n = 0; n < 4; n++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        psel_a[i]    = 1'b1;
        penable_a[i] = 1'b1;
        paddr_a[i]   = 16'($urandom());
      end
    end
    step();
    chk("t6_busy", 0, 16'(busy_a[0]), 16'h0000);
    chk("t6_busy", 2, 16'(busy_a[2]), 16'h0000);

    // Randomized transfers across all instances.
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, NI - 1);
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom());
        1:       a = 16'(base_of(k) + 16'($urandom_range(0, 7)));
        default: a = 16'(base_of(k) + 16'($urandom_range(0, DEP - 1)));
      endcase
      if ($urandom_range(0, 7) == 0) begin
        cut_kind = 1;
        cut_j    = $urandom_range(0, ws_of(k));
      end else begin
        cut_kind = 0;
        cut_j    = -1;
      end
      xfer(k, w, a, 16'($urandom()), cut_j, cut_kind);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          step();
          if ($urandom_range(0, 1) == 1) penable_a[k] = 1'b1;
        end
      end
    end
    step();
    step();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
